// File: rtl/mc_sequencer_if.sv
// Control bus between the multicycle sequencer and its datapath.
// Carries the instruction-register bits and ALU flags into the sequencer,
// and carries every mux select, write enable and the debug state back out.
//   master : sequencer side (consumes Instr/ALUFlags, drives controls)
//   slave  : datapath side  (drives Instr/ALUFlags, consumes controls)
interface mc_sequencer_if;
  logic [19:0] Instr;
  logic [3:0]  ALUFlags;
  logic        PCWrite;
  logic        AdrSrc;
  logic        MemWrite;
  logic        IRWrite;
  logic        RegWrite;
  logic [1:0]  ResultSrc;
  logic [1:0]  ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [1:0]  ALUControl;
  logic [1:0]  ImmSrc;
  logic [1:0]  RegSrc;
  logic [3:0]  State;

  modport master (
    input  Instr, ALUFlags,
    output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc, State
  );

  modport slave (
    output Instr, ALUFlags,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc, State
  );
endinterface

// File: rtl/mc_sequencer.sv
// Multicycle control sequencer for the ARMv4-subset core.
// A Moore FSM steps the shared ALU, unified memory port and instruction
// register through fetch/decode/execute/writeback, and owns the NZCV flag
// register plus the condition-execute latch.
// Ports:
//   clk   : system clock, all state changes on posedge
//   reset : synchronous, active-high
//   bus   : mc_sequencer_if.master (Instr/ALUFlags in; all controls + State out)
module mc_sequencer #(
  parameter bit ENABLE_NOWRITE = 1'b1
) (
  input logic              clk,
  input logic              reset,
  mc_sequencer_if.master   bus
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXER   = 4'd6,
    EXEI   = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9
  } state_t;

  state_t      state, state_next, out_state;
  logic [3:0]  flags;
  logic        cond_ex;

  logic [3:0]  cond, cmd, rd;
  logic [1:0]  op;
  logic        imm_bit, s_bit;

  logic [1:0]  alu_op;
  logic        cmd_ok, no_write, cv_cmd;

  logic        pcw_fetch, irw, regw, memw, branch, exe;
  logic        nz_we, cv_we;

  assign cond    = bus.Instr[19:16];
  assign op      = bus.Instr[15:14];
  assign imm_bit = bus.Instr[13];
  assign cmd     = bus.Instr[12:9];
  assign s_bit   = bus.Instr[8];    // S for data-processing, L for memory
  assign rd      = bus.Instr[3:0];

  function automatic logic cond_check(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    {n, z, cf, v} = f;
    case (c)
      4'b0000: return z;
      4'b0001: return ~z;
      4'b0010: return cf;
      4'b0011: return ~cf;
      4'b0100: return n;
      4'b0101: return ~n;
      4'b0110: return v;
      4'b0111: return ~v;
      4'b1000: return cf & ~z;
      4'b1001: return ~cf | z;
      4'b1010: return n == v;
      4'b1011: return n != v;
      4'b1100: return ~z & (n == v);
      4'b1101: return z | (n != v);
      4'b1110: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Data-processing command decode; unsupported commands leave cmd_ok low.
  always_comb begin
    alu_op   = 2'b00;
    cmd_ok   = 1'b0;
    no_write = 1'b0;
    cv_cmd   = 1'b0;
    case (cmd)
      4'b0100: begin alu_op = 2'b00; cmd_ok = 1'b1; cv_cmd = 1'b1; end
      4'b0010: begin alu_op = 2'b01; cmd_ok = 1'b1; cv_cmd = 1'b1; end
      4'b0000: begin alu_op = 2'b10; cmd_ok = 1'b1; end
      4'b1100: begin alu_op = 2'b11; cmd_ok = 1'b1; end
      4'b1010: if (ENABLE_NOWRITE) begin
        alu_op = 2'b01; cmd_ok = 1'b1; no_write = 1'b1; cv_cmd = 1'b1;
      end
      4'b1000: if (ENABLE_NOWRITE) begin
        alu_op = 2'b10; cmd_ok = 1'b1; no_write = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= FETCH;
      flags   <= '0;
      cond_ex <= 1'b0;
    end else begin
      state <= state_next;
      if (state == DECODE) cond_ex <= cond_check(cond, flags);
      if (nz_we) flags[3:2] <= bus.ALUFlags[3:2];
      if (cv_we) flags[1:0] <= bus.ALUFlags[1:0];
    end
  end

  // While reset is high the selects show FETCH values; enables are masked below.
  assign out_state = reset ? FETCH : state;

  always_comb begin
    state_next     = FETCH;
    pcw_fetch      = 1'b0;
    irw            = 1'b0;
    regw           = 1'b0;
    memw           = 1'b0;
    branch         = 1'b0;
    exe            = 1'b0;
    bus.AdrSrc     = 1'b0;
    bus.ResultSrc  = 2'b00;
    bus.ALUSrcA    = 2'b00;
    bus.ALUSrcB    = 2'b00;
    bus.ALUControl = 2'b00;

    case (state)
      FETCH:  state_next = DECODE;
      DECODE: case (op)
        2'b00:   state_next = imm_bit ? EXEI : EXER;
        2'b01:   state_next = MEMADR;
        2'b10:   state_next = BRANCH;
        default: state_next = FETCH;
      endcase
      MEMADR: state_next = s_bit ? MEMRD : MEMWR;
      MEMRD:  state_next = MEMWB;
      EXER,
      EXEI:   state_next = ALUWB;
      default: state_next = FETCH;
    endcase

    case (out_state)
      FETCH: begin
        bus.ALUSrcA = 2'b01; bus.ALUSrcB = 2'b10; bus.ResultSrc = 2'b10;
        irw = 1'b1; pcw_fetch = 1'b1;
      end
      DECODE: begin
        bus.ALUSrcA = 2'b01; bus.ALUSrcB = 2'b10; bus.ResultSrc = 2'b10;
      end
      MEMADR: bus.ALUSrcB = 2'b01;
      MEMRD:  bus.AdrSrc = 1'b1;
      MEMWB: begin
        bus.ResultSrc = 2'b01; regw = 1'b1;
      end
      MEMWR: begin
        bus.AdrSrc = 1'b1; memw = 1'b1;
      end
      EXER: begin
        bus.ALUControl = alu_op; exe = 1'b1;
      end
      EXEI: begin
        bus.ALUSrcB = 2'b01; bus.ALUControl = alu_op; exe = 1'b1;
      end
      ALUWB:  regw = cmd_ok & ~no_write;
      BRANCH: begin
        bus.ALUSrcB = 2'b01; bus.ResultSrc = 2'b10; branch = 1'b1;
      end
      default: ;
    endcase
  end

  assign nz_we = exe & s_bit & cmd_ok & cond_ex;
  assign cv_we = nz_we & cv_cmd;

  assign bus.IRWrite  = ~reset & irw;
  assign bus.RegWrite = ~reset & regw & cond_ex;
  assign bus.MemWrite = ~reset & memw & cond_ex;
  assign bus.PCWrite  = ~reset & (pcw_fetch | (cond_ex & (branch | (regw & (rd == 4'hF)))));

  assign bus.ImmSrc = op;
  assign bus.RegSrc = {(op == 2'b01) & ~s_bit, op == 2'b10};
  assign bus.State  = state;

endmodule
